// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read channel between the I-cache and D-cache refill engines.
// One fixed-length INCR burst in flight; aborted I-side bursts are drained and discarded.
module axi_read_arbiter #(
    parameter int DATA_LENGTH = 32,
    parameter int BURST_LEN   = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic [31:0]            i_araddr,
    input  logic                   i_arvalid,
    output logic                   i_arready,
    input  logic                   i_abort,
    output logic [DATA_LENGTH-1:0] i_rdata,
    output logic                   i_rvalid,
    output logic                   i_rlast,

    input  logic [31:0]            d_araddr,
    input  logic                   d_arvalid,
    output logic                   d_arready,
    output logic [DATA_LENGTH-1:0] d_rdata,
    output logic                   d_rvalid,
    output logic                   d_rlast,

    output logic [31:0]            ARADDR,
    output logic [3:0]             ARLEN,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [DATA_LENGTH-1:0] RDATA,
    input  logic                   RVALID,
    input  logic                   RLAST,
    output logic                   RREADY,

    output logic                   busy,
    output logic                   burst_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    localparam logic             OWN_I    = 1'b0;
    localparam logic             OWN_D    = 1'b1;
    localparam int               CW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(BURST_LEN - 1);

    state_t        state_q;
    logic          owner_q;
    logic          last_owner_q;
    logic [CW-1:0] cnt_q;
    logic          overrun_q;
    logic          abort_pend_q;
    logic [31:0]   araddr_q;
    logic          arvalid_q;
    logic          rready_q;
    logic          burst_err_q;

    logic          grant_d;
    logic          abort_hit;
    logic [1:0]    arready_s;
    logic [1:0]    rvalid_s;
    logic [1:0]    rlast_s;
    logic [1:0]    abort_s;

    // On a tie the side that did not own the previous burst wins.
    assign grant_d   = d_arvalid && (!i_arvalid || last_owner_q == OWN_I);
    assign abort_hit = i_abort && (owner_q == OWN_I);
    assign abort_s   = {1'b0, i_abort};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            assign arready_s[gi] = (state_q == ADDR) && (owner_q == 1'(gi)) && ARREADY;
            assign rvalid_s[gi]  = (state_q == DATA) && (owner_q == 1'(gi)) && RVALID && !abort_s[gi];
            assign rlast_s[gi]   = rvalid_s[gi] && RLAST;
        end
    endgenerate

    assign i_arready = arready_s[0];
    assign d_arready = arready_s[1];
    assign i_rvalid  = rvalid_s[0];
    assign d_rvalid  = rvalid_s[1];
    assign i_rlast   = rlast_s[0];
    assign d_rlast   = rlast_s[1];
    assign i_rdata   = RDATA;
    assign d_rdata   = RDATA;

    assign ARADDR    = araddr_q;
    assign ARLEN     = 4'(BURST_LEN - 1);
    assign ARVALID   = arvalid_q;
    assign RREADY    = rready_q;
    assign busy      = (state_q != IDLE);
    assign burst_err = burst_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            burst_err_q  <= 1'b0;
        end else begin
            burst_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_arvalid || d_arvalid) begin
                        araddr_q     <= grant_d ? d_araddr : i_araddr;
                        arvalid_q    <= 1'b1;
                        owner_q      <= grant_d;
                        last_owner_q <= grant_d;
                        abort_pend_q <= 1'b0;
                        state_q      <= ADDR;
                    end
                end
                ADDR: begin
                    // The address beat cannot be withdrawn; remember the abort and drain later.
                    if (abort_hit) begin
                        abort_pend_q <= 1'b1;
                    end
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        overrun_q <= 1'b0;
                        state_q   <= (abort_pend_q || abort_hit) ? DRAIN : DATA;
                    end
                end
                DATA, DRAIN: begin
                    if (RVALID) begin
                        if (RLAST) begin
                            burst_err_q <= (cnt_q != LAST_CNT);
                            rready_q    <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            if (cnt_q == LAST_CNT) begin
                                burst_err_q <= !overrun_q;
                                overrun_q   <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                            if (state_q == DATA && abort_hit) begin
                                state_q <= DRAIN;
                            end
                        end
                    end else if (state_q == DATA && abort_hit) begin
                        state_q <= DRAIN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: grants, round-robin, aborts, RLAST checks, reset.
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_araddr, d_araddr;
    logic        i_arvalid, d_arvalid, i_abort;
    logic        i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rvalid, i_rlast, d_rvalid, d_rlast;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic        RVALID, RLAST, RREADY;
    logic        busy, burst_err;

    int tests = 0;
    int fails = 0;

    axi_read_arbiter #(.DATA_LENGTH(32), .BURST_LEN(16)) dut (
        .clk(clk), .rst(rst),
        .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready), .i_abort(i_abort),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_araddr(d_araddr), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
        .busy(busy), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold ARREADY low for 'waits' cycles (optionally aborting), then handshake.
    task automatic hs(input int waits, input logic ab, output int av_hi, output logic ia, output logic da);
        av_hi = 0;
        for (int k = 0; k < waits; k++) begin
            ARREADY = 1'b0;
            i_abort = ab;
            #1;
            if (ARVALID) av_hi++;
            tick();
        end
        i_abort = 1'b0;
        ARREADY = 1'b1;
        #1;
        ia = i_arready;
        da = d_arready;
        tick();
        ARREADY = 1'b0;
    endtask

    // Send n back-to-back beats; RLAST on beat last_at, i_abort on beat abort_at.
    task automatic burst(input int n, input int last_at, input int abort_at,
                         output int ic, output int dc, output int lb,
                         output int errs, output int derr, output int rr_lo);
        ic = 0; dc = 0; lb = -1; errs = 0; derr = 0; rr_lo = 0;
        for (int b = 0; b < n; b++) begin
            RVALID  = 1'b1;
            RDATA   = 32'hA000 + 32'(b);
            RLAST   = (b == last_at);
            i_abort = (b == abort_at);
            #1;
            if (!RREADY) rr_lo++;
            if (i_rvalid) begin
                ic++;
                if (i_rdata !== 32'hA000 + 32'(b)) derr++;
            end
            if (d_rvalid) begin
                dc++;
                if (d_rdata !== 32'hA000 + 32'(b)) derr++;
            end
            if (i_rlast || d_rlast) lb = b;
            tick();
            if (burst_err) errs++;
        end
        RVALID  = 1'b0;
        RLAST   = 1'b0;
        i_abort = 1'b0;
    endtask

    int   ic, dc, lb, er, de, rl, av;
    logic ia, da;

    initial begin
        rst = 1'b1;
        i_araddr = '0; d_araddr = '0;
        i_arvalid = 1'b0; d_arvalid = 1'b0; i_abort = 1'b0;
        ARREADY = 1'b0; RDATA = '0; RVALID = 1'b0; RLAST = 1'b0;
        tick();
        tick();
        chk("rst_arvalid", 32'(ARVALID), 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_rready", 32'(RREADY), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_burst_err", 32'(burst_err), 0);
        chk("rst_i_rvalid", 32'(i_rvalid), 0);
        chk("arlen", 32'(ARLEN), 15);

        // Single I request, ARREADY after 2 cycles
        rst = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h0000_1040;
        tick();
        chk("t1_arvalid", 32'(ARVALID), 1);
        chk("t1_araddr", ARADDR, 32'h0000_1040);
        chk("t1_busy", 32'(busy), 1);
        hs(2, 1'b0, av, ia, da);
        i_arvalid = 1'b0;
        chk("t1_arvalid_held", 32'(av), 2);
        chk("t1_i_arready", 32'(ia), 1);
        chk("t1_d_arready", 32'(da), 0);
        chk("t1_arvalid_drop", 32'(ARVALID), 0);
        chk("t1_rready_up", 32'(RREADY), 1);
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t1_i_beats", 32'(ic), 16);
        chk("t1_d_beats", 32'(dc), 0);
        chk("t1_rlast_beat", 32'(lb), 15);
        chk("t1_burst_err", 32'(er), 0);
        chk("t1_data", 32'(de), 0);
        chk("t1_idle", 32'(busy), 0);
        chk("t1_rready_down", 32'(RREADY), 0);

        // Tie after reset: I first; I re-requests while D waits, so D goes next
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h100;
        d_arvalid = 1'b1; d_araddr = 32'h200;
        tick();
        chk("t2_tie_first", ARADDR, 32'h100);
        hs(0, 1'b0, av, ia, da);
        chk("t2_i_arready", 32'(ia), 1);
        chk("t2_d_arready_low", 32'(da), 0);
        i_araddr = 32'h140;
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t2_i_beats", 32'(ic), 16);
        chk("t2_d_beats_none", 32'(dc), 0);
        tick();
        chk("t2_rr_d", ARADDR, 32'h200);
        hs(1, 1'b0, av, ia, da);
        chk("t2_d_arready", 32'(da), 1);
        chk("t2_i_arready_low", 32'(ia), 0);
        d_arvalid = 1'b0;
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t2_d_beats", 32'(dc), 16);
        chk("t2_i_beats_none", 32'(ic), 0);
        chk("t2_d_data", 32'(de), 0);
        tick();
        chk("t2_i_again", ARADDR, 32'h140);
        hs(0, 1'b0, av, ia, da);
        i_arvalid = 1'b0;
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t2_i2_beats", 32'(ic), 16);

        // Abort on DATA beat 5, D request pending
        i_arvalid = 1'b1; i_araddr = 32'h300;
        tick();
        chk("t3_araddr", ARADDR, 32'h300);
        hs(0, 1'b0, av, ia, da);
        i_arvalid = 1'b0;
        d_arvalid = 1'b1; d_araddr = 32'h400;
        burst(16, 15, 5, ic, dc, lb, er, de, rl);
        chk("t3_i_beats", 32'(ic), 5);
        chk("t3_d_beats", 32'(dc), 0);
        chk("t3_no_rlast", 32'(lb), 32'hFFFF_FFFF);
        chk("t3_rready_held", 32'(rl), 0);
        chk("t3_idle", 32'(busy), 0);
        tick();
        chk("t3_d_grant", ARADDR, 32'h400);
        chk("t3_d_arvalid", 32'(ARVALID), 1);
        hs(0, 1'b0, av, ia, da);
        d_arvalid = 1'b0;
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t3_d_full", 32'(dc), 16);

        // Abort while waiting for ARREADY
        i_arvalid = 1'b1; i_araddr = 32'h500;
        tick();
        hs(3, 1'b1, av, ia, da);
        i_arvalid = 1'b0;
        chk("t4_arvalid_held", 32'(av), 3);
        chk("t4_i_arready", 32'(ia), 1);
        chk("t4_draining", 32'(busy), 1);
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t4_i_beats", 32'(ic), 0);
        chk("t4_d_beats", 32'(dc), 0);
        chk("t4_rready_held", 32'(rl), 0);
        chk("t4_idle", 32'(busy), 0);

        // Early RLAST on beat 9
        i_arvalid = 1'b1; i_araddr = 32'h600;
        tick();
        hs(0, 1'b0, av, ia, da);
        i_arvalid = 1'b0;
        burst(10, 9, -1, ic, dc, lb, er, de, rl);
        chk("t5_early_err", 32'(er), 1);
        chk("t5_early_beats", 32'(ic), 10);
        chk("t5_early_idle", 32'(busy), 0);
        tick();
        chk("t5_err_single", 32'(burst_err), 0);

        // Missing RLAST at beat 15; RLAST finally on beat 17
        i_arvalid = 1'b1; i_araddr = 32'h640;
        tick();
        hs(0, 1'b0, av, ia, da);
        i_arvalid = 1'b0;
        burst(18, 17, -1, ic, dc, lb, er, de, rl);
        chk("t5_late_err", 32'(er), 1);
        chk("t5_late_beats", 32'(ic), 18);
        chk("t5_late_rlast", 32'(lb), 17);
        chk("t5_late_idle", 32'(busy), 0);

        // Reset in the middle of an I burst, then tie goes to I
        i_arvalid = 1'b1; i_araddr = 32'h700;
        tick();
        hs(0, 1'b0, av, ia, da);
        i_arvalid = 1'b0;
        burst(3, -1, -1, ic, dc, lb, er, de, rl);
        chk("t6_mid_beats", 32'(ic), 3);
        rst = 1'b1;
        tick();
        chk("t6_arvalid", 32'(ARVALID), 0);
        chk("t6_rready", 32'(RREADY), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_err", 32'(burst_err), 0);
        rst = 1'b0;
        i_arvalid = 1'b1; i_araddr = 32'h800;
        d_arvalid = 1'b1; d_araddr = 32'h900;
        tick();
        chk("t6_tie_i", ARADDR, 32'h800);
        hs(0, 1'b0, av, ia, da);
        chk("t6_i_arready", 32'(ia), 1);
        i_arvalid = 1'b0;
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t6_i_beats", 32'(ic), 16);
        tick();
        chk("t6_then_d", ARADDR, 32'h900);
        hs(0, 1'b0, av, ia, da);
        d_arvalid = 1'b0;
        burst(16, 15, -1, ic, dc, lb, er, de, rl);
        chk("t6_d_beats", 32'(dc), 16);
        chk("t6_d_rlast", 32'(lb), 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
